// File: rtl/capture_ctrl_nch_if.sv
// Bus bundle for capture_ctrl_nch: sample strobe, channel levels/config, control pulses,
// and the shared channel-RAM write port plus capture status.
interface capture_ctrl_nch_if #(
    parameter int NUM_CH = 5,
    parameter int LOG2   = 9
);
    logic                  wrt_smpl;
    logic [NUM_CH-1:0]     CHxHff5;
    logic [NUM_CH-1:0]     CHxLff5;
    logic [5*NUM_CH-1:0]   CHxTrigCfg;
    logic                  protTrig;
    logic                  prot_en;
    logic [LOG2-1:0]       trig_pos;
    logic                  start;
    logic                  abort;
    logic                  clr_done;
    logic                  we;
    logic [LOG2-1:0]       waddr;
    logic                  armed;
    logic                  triggered;
    logic                  capture_done;
    logic [LOG2-1:0]       rd_start;
    logic [31:0]           trig_tstamp;

    modport master (
        output wrt_smpl, CHxHff5, CHxLff5, CHxTrigCfg, protTrig, prot_en, trig_pos,
               start, abort, clr_done,
        input  we, waddr, armed, triggered, capture_done, rd_start, trig_tstamp
    );

    modport slave (
        input  wrt_smpl, CHxHff5, CHxLff5, CHxTrigCfg, protTrig, prot_en, trig_pos,
               start, abort, clr_done,
        output we, waddr, armed, triggered, capture_done, rd_start, trig_tstamp
    );
endinterface

// File: rtl/capture_ctrl_nch.sv
// N-channel trigger evaluator with pre/post-trigger circular-buffer capture FSM.
// Optional feature macro: TRIG_TSTAMP_EN (ARMED-phase sample counter on trig_tstamp).
module capture_ctrl_nch #(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic               clk,
    input  logic               rst,
    capture_ctrl_nch_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

    localparam logic [LOG2-1:0] LAST  = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   DEPTH = (LOG2 + 1)'(ENTRIES);

    state_t              r_state;
    logic [LOG2-1:0]     r_waddr;
    logic [LOG2-1:0]     r_rd_start;
    logic [LOG2-1:0]     r_tp;
    logic [LOG2-1:0]     r_pre_cnt;
    logic [LOG2-1:0]     r_post_cnt;
    logic [NUM_CH-1:0]   r_prev_h;
    logic [NUM_CH-1:0]   r_prev_l;
    logic                r_armed;
    logic                r_triggered;
    logic                r_done;

    logic                w_capturing;
    logic                w_we;
    logic [LOG2-1:0]     w_waddr_inc;
    logic [LOG2-1:0]     w_tp_in;
    logic                w_pre_last;
    logic                w_post_last;
    logic [NUM_CH-1:0]   w_chan_ok;
    logic                w_trig_q;
    logic                w_start_ok;

    assign w_capturing = (r_state == PRE) || (r_state == ARMED) || (r_state == POST);
    assign w_we        = bus.wrt_smpl & w_capturing;
    assign w_waddr_inc = (r_waddr == LAST) ? '0 : r_waddr + LOG2'(1);
    assign w_tp_in     = (bus.trig_pos > LAST) ? LAST : bus.trig_pos;
    assign w_start_ok  = (r_state == IDLE) && bus.start && !bus.abort;

    // Pre-fill length is ENTRIES-tp, which reaches ENTRIES when tp==0, hence the extra bit.
    assign w_pre_last  = ({1'b0, r_pre_cnt} + (LOG2 + 1)'(1)) == (DEPTH - {1'b0, r_tp});
    assign w_post_last = (r_post_cnt + LOG2'(1)) == r_tp;

    // cfg bits per channel: [4] rise, [3] fall, [2] high, [1] low, [0] dont_care.
    always_comb begin
        w_chan_ok = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_chan_ok[ch] = bus.CHxTrigCfg[5*ch]
                          | (bus.CHxTrigCfg[5*ch+4] &  bus.CHxHff5[ch] & ~r_prev_h[ch])
                          | (bus.CHxTrigCfg[5*ch+3] & ~bus.CHxLff5[ch] &  r_prev_l[ch])
                          | (bus.CHxTrigCfg[5*ch+2] &  bus.CHxHff5[ch])
                          | (bus.CHxTrigCfg[5*ch+1] & ~bus.CHxLff5[ch]);
        end
    end

    assign w_trig_q = (&w_chan_ok) & (~bus.prot_en | bus.protTrig);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_waddr     <= '0;
            r_rd_start  <= '0;
            r_tp        <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_prev_h    <= '0;
            r_prev_l    <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_we) r_waddr <= w_waddr_inc;
            if (bus.wrt_smpl) begin
                r_prev_h <= bus.CHxHff5;
                r_prev_l <= bus.CHxLff5;
            end
            if (bus.abort && (r_state != IDLE)) begin
                r_state     <= IDLE;
                r_armed     <= 1'b0;
                r_triggered <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (w_start_ok) begin
                        r_state   <= PRE;
                        r_pre_cnt <= '0;
                        r_tp      <= w_tp_in;
                    end
                    PRE: if (bus.wrt_smpl) begin
                        r_pre_cnt <= r_pre_cnt + LOG2'(1);
                        if (w_pre_last) begin
                            r_state <= ARMED;
                            r_armed <= 1'b1;
                        end
                    end
                    ARMED: if (bus.wrt_smpl && w_trig_q) begin
                        r_armed     <= 1'b0;
                        r_triggered <= 1'b1;
                        if (r_tp == '0) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_rd_start <= w_waddr_inc;
                        end else begin
                            r_state    <= POST;
                            r_post_cnt <= '0;
                        end
                    end
                    POST: if (bus.wrt_smpl) begin
                        r_post_cnt <= r_post_cnt + LOG2'(1);
                        if (w_post_last) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_rd_start <= w_waddr_inc;
                        end
                    end
                    DONE: if (bus.clr_done) begin
                        r_state     <= IDLE;
                        r_triggered <= 1'b0;
                        r_done      <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef TRIG_TSTAMP_EN
    logic [31:0] r_tstamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tstamp <= '0;
        end else if (w_start_ok) begin
            r_tstamp <= '0;
        end else if ((r_state == ARMED) && bus.wrt_smpl && !w_trig_q && (r_tstamp != '1)) begin
            r_tstamp <= r_tstamp + 32'd1;
        end
    end

    assign bus.trig_tstamp = r_tstamp;
`else
    assign bus.trig_tstamp = '0;
`endif

    assign bus.we           = w_we;
    assign bus.waddr        = r_waddr;
    assign bus.rd_start     = r_rd_start;
    assign bus.armed        = r_armed;
    assign bus.triggered    = r_triggered;
    assign bus.capture_done = r_done;
endmodule
